// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL bit positions, mode codes and FSM state encoding.
package timer_counter_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int TC_EN      = 0;
  localparam int TC_MODE_LO = 1;
  localparam int TC_MODE_HI = 2;
  localparam int TC_IM      = 3;
  localparam int TC_CTRL_W  = 4;

  localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

endpackage

// File: rtl/timer_counter.sv
// Countdown timer on the CPU data bus: CTRL/PRESET/COUNT registers with
// byte-enabled stores, combinational reads and a one-shot/auto-reload FSM.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_e               state_q;
  logic [TC_CTRL_W-1:0]    ctrl_q;
  logic [31:0]             preset_q;
  logic [31:0]             count_q;
  logic                    irq_flag_q;

  logic                    hit;
  logic [1:0]              sel;
  logic                    wr_ctrl, wr_preset;
  logic [TC_CTRL_W-1:0]    ctrl_wr_d;
  logic [31:0]             preset_wr_d;
  logic                    unused_addr;

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  assign hit         = (addr[31:4] == BASE[31:4]);
  assign sel         = addr[3:2];
  assign unused_addr = ^addr[1:0];

  assign wr_ctrl   = hit && (byteen != 4'd0) && (sel == TC_CTRL);
  assign wr_preset = hit && (byteen != 4'd0) && (sel == TC_PRESET);

  // Only the low nibble of CTRL is stored, so only byte lane 0 matters.
  assign ctrl_wr_d   = byteen[0] ? wdata[TC_CTRL_W-1:0] : ctrl_q;
  assign preset_wr_d = byte_merge(preset_q, wdata, byteen);

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (sel)
        TC_CTRL:   rdata = {{(32-TC_CTRL_W){1'b0}}, ctrl_q};
        TC_PRESET: rdata = preset_q;
        TC_COUNT:  rdata = count_q;
        default:   rdata = 32'd0;
      endcase
    end
  end

  assign irq = irq_flag_q & ctrl_q[TC_IM];

  // Bus writes are applied after the FSM so they win on a shared edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= TC_IDLE;
      ctrl_q     <= '0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      case (state_q)
        TC_IDLE: begin
          if (ctrl_q[TC_EN]) begin
            irq_flag_q <= 1'b0;
            state_q    <= TC_LOAD;
          end
        end
        TC_LOAD: begin
          count_q <= preset_q;
          state_q <= TC_CNT;
        end
        TC_CNT: begin
          if (!ctrl_q[TC_EN]) begin
            state_q <= TC_IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q    <= 32'd0;
            irq_flag_q <= 1'b1;
            state_q    <= TC_INT;
          end
        end
        TC_INT: begin
          state_q <= TC_IDLE;
          if (ctrl_q[TC_MODE_HI:TC_MODE_LO] == TC_MODE_RELOAD)
            irq_flag_q <= 1'b0;
          else
            ctrl_q[TC_EN] <= 1'b0;
        end
        default: state_q <= TC_IDLE;
      endcase

      if (wr_ctrl) begin
        ctrl_q     <= ctrl_wr_d;
        irq_flag_q <= 1'b0;
      end
      if (wr_preset) preset_q <= preset_wr_d;
    end
  end

endmodule
